// File: rtl/vga_layer_compositor.sv
// Priority compositor for up to eight graphic layers. PicoBlaze-programmable
// enable/blink masks and background colour, two free-running blink generators, registered RGB output.
module vga_layer_compositor #(
  parameter int          LAYERS     = 6,
  parameter int          RGB_W      = 8,
  parameter int          BLINK0_MAX = 16666666,
  parameter int          BLINK1_MAX = 24999999,
  parameter int          BLINK_W    = 25,
  parameter logic [7:0]  PORT_BASE  = 8'h40
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pixel_tick,
  input  logic                    video_on,
  input  logic [LAYERS-1:0]       layer_on,
  input  logic [LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [7:0]              port_id,
  input  logic [7:0]              in_dato,
  input  logic                    write_strobe,
  output logic [RGB_W-1:0]        rgb,
  output logic                    blink0,
  output logic                    blink1
);

  localparam logic [7:0] ADDR_MASK      = PORT_BASE;
  localparam logic [7:0] ADDR_BLINK_EN  = PORT_BASE + 8'd1;
  localparam logic [7:0] ADDR_BLINK_SEL = PORT_BASE + 8'd2;
  localparam logic [7:0] ADDR_BG        = PORT_BASE + 8'd3;

  localparam logic [BLINK_W-1:0] BLINK0_TC = BLINK_W'(BLINK0_MAX);
  localparam logic [BLINK_W-1:0] BLINK1_TC = BLINK_W'(BLINK1_MAX);

  logic [LAYERS-1:0]  en_mask;
  logic [LAYERS-1:0]  blink_en;
  logic [LAYERS-1:0]  blink_sel;
  logic [RGB_W-1:0]   bg_colour;
  logic [RGB_W-1:0]   bg_next;
  logic [BLINK_W-1:0] blink_cnt0;
  logic [BLINK_W-1:0] blink_cnt1;
  logic [LAYERS-1:0]  sel_state;
  logic [LAYERS-1:0]  eligible;
  logic [RGB_W-1:0]   selected;

  // Write data is 8 bits wide; wider colours get zero-extended.
  generate
    if (RGB_W > 8) begin : g_bg_wide
      assign bg_next = {{(RGB_W-8){1'b0}}, in_dato};
    end else begin : g_bg_narrow
      assign bg_next = in_dato[RGB_W-1:0];
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_mask   <= '1;
      blink_en  <= '0;
      blink_sel <= '0;
      bg_colour <= '0;
    end else if (write_strobe) begin
      case (port_id)
        ADDR_MASK:      en_mask   <= in_dato[LAYERS-1:0];
        ADDR_BLINK_EN:  blink_en  <= in_dato[LAYERS-1:0];
        ADDR_BLINK_SEL: blink_sel <= in_dato[LAYERS-1:0];
        ADDR_BG:        bg_colour <= bg_next;
        default: ;
      endcase
    end
  end

  // Blink generators run on the system clock, not the pixel clock, so their
  // rate is independent of the video mode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_cnt0 <= '0;
      blink0     <= 1'b0;
    end else if (blink_cnt0 == BLINK0_TC) begin
      blink_cnt0 <= '0;
      blink0     <= ~blink0;
    end else begin
      blink_cnt0 <= blink_cnt0 + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_cnt1 <= '0;
      blink1     <= 1'b0;
    end else if (blink_cnt1 == BLINK1_TC) begin
      blink_cnt1 <= '0;
      blink1     <= ~blink1;
    end else begin
      blink_cnt1 <= blink_cnt1 + 1'b1;
    end
  end

  assign sel_state = (blink_sel & {LAYERS{blink1}}) | (~blink_sel & {LAYERS{blink0}});
  assign eligible  = layer_on & en_mask & (~blink_en | sel_state);

  // Scan from the top index down so the lowest eligible index is written last and wins.
  always_comb begin
    selected = bg_colour;
    for (int i = LAYERS-1; i >= 0; i--) begin
      if (eligible[i]) selected = layer_rgb[i*RGB_W +: RGB_W];
    end
    if (!video_on) selected = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rgb <= '0;
    end else if (pixel_tick) begin
      rgb <= selected;
    end
  end

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Self-checking bench for vga_layer_compositor: a vector table plus blink,
// same-edge and mid-operation reset sequences, checked through a scoreboard queue.
module tb_vga_layer_compositor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pixel_tick = 1'b0;
  logic        video_on = 1'b0;
  logic [3:0]  layer_on = '0;
  logic [31:0] layer_rgb = 32'h44332211;
  logic [7:0]  port_id = '0;
  logic [7:0]  in_dato = '0;
  logic        write_strobe = 1'b0;
  logic [7:0]  rgb;
  logic        blink0;
  logic        blink1;

  vga_layer_compositor #(
    .LAYERS(4), .RGB_W(8), .BLINK0_MAX(3), .BLINK1_MAX(5), .BLINK_W(25), .PORT_BASE(8'h40)
  ) dut (
    .clock(clock), .reset(reset), .pixel_tick(pixel_tick), .video_on(video_on),
    .layer_on(layer_on), .layer_rgb(layer_rgb), .port_id(port_id), .in_dato(in_dato),
    .write_strobe(write_strobe), .rgb(rgb), .blink0(blink0), .blink1(blink1)
  );

  always #5 clock = ~clock;

  // Reference blink generators: toggle every MAX+1 clocks from reset release.
  int   m_cnt0, m_cnt1;
  logic m_b0, m_b1;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_cnt0 <= 0; m_cnt1 <= 0; m_b0 <= 1'b0; m_b1 <= 1'b0;
    end else begin
      if (m_cnt0 == 3) begin m_cnt0 <= 0; m_b0 <= ~m_b0; end else m_cnt0 <= m_cnt0 + 1;
      if (m_cnt1 == 5) begin m_cnt1 <= 0; m_b1 <= ~m_b1; end else m_cnt1 <= m_cnt1 + 1;
    end
  end

  typedef struct {
    logic [7:0] rgb;
    string      name;
  } exp_t;

  typedef struct {
    logic       vo;
    logic [3:0] lon;
    logic       tick;
    logic       wr;
    logic [7:0] port;
    logic [7:0] data;
    logic [7:0] exp_rgb;
    string      name;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[16];
  int         checks = 0;
  int         passes = 0;
  logic [7:0] last_exp = 8'h00;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checkValue("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      checkValue(e.name, {24'h0, rgb}, {24'h0, e.rgb});
    end
    checkValue("blink0", {31'h0, blink0}, {31'h0, m_b0});
    checkValue("blink1", {31'h0, blink1}, {31'h0, m_b1});
  endtask

  // One clock: drive at the falling edge, expect the result after the rising edge.
  task automatic applyStimulus(input logic vo, input logic [3:0] lon, input logic tick,
                               input logic wr, input logic [7:0] port, input logic [7:0] data,
                               input logic [7:0] exp_rgb, input string name);
    exp_t e;
    @(negedge clock);
    video_on = vo; layer_on = lon; pixel_tick = tick;
    write_strobe = wr; port_id = port; in_dato = data;
    e.rgb = exp_rgb; e.name = name;
    sb.push_back(e);
    last_exp = exp_rgb;
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  task automatic holdStep();
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 8'h00, last_exp, "hold");
  endtask

  task automatic measureHalf(input bit use_b1, input int expect_len, input string name);
    int   first = -1;
    int   second = -1;
    logic prev = use_b1 ? blink1 : blink0;
    logic cur;
    for (int c = 0; c < 3*expect_len + 4 && second < 0; c++) begin
      holdStep();
      cur = use_b1 ? blink1 : blink0;
      if (cur !== prev) begin
        if (first < 0) first = c; else second = c;
      end
      prev = cur;
    end
    if (second < 0) $display("[TB] FAIL %s: timeout waiting for blink toggle", name);
    checkValue(name, (second < 0) ? 32'hFFFF_FFFF : 32'(second - first), 32'(expect_len));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // layer_rgb = {44,33,22,11}: layer0=11 .. layer3=44; reset config mask=F, bg=0
    vecs[0]  = '{1'b1, 4'b0110, 1'b1, 1'b0, 8'h00, 8'h00, 8'h22, "priority"};
    vecs[1]  = '{1'b1, 4'b0001, 1'b0, 1'b0, 8'h00, 8'h00, 8'h22, "hold_no_tick"};
    vecs[2]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 8'h00, 8'h22, "hold_no_tick2"};
    vecs[3]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, "bg_reset_value"};
    vecs[4]  = '{1'b1, 4'b0010, 1'b0, 1'b1, 8'h40, 8'h0D, 8'h00, "write_mask"};
    vecs[5]  = '{1'b1, 4'b0010, 1'b0, 1'b1, 8'h43, 8'hE3, 8'h00, "write_bg"};
    vecs[6]  = '{1'b1, 4'b0010, 1'b1, 1'b0, 8'h00, 8'h00, 8'hE3, "masked_to_bg"};
    vecs[7]  = '{1'b1, 4'b0110, 1'b1, 1'b0, 8'h00, 8'h00, 8'h33, "masked_next"};
    vecs[8]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, "blanking"};
    vecs[9]  = '{1'b1, 4'b1000, 1'b1, 1'b0, 8'h00, 8'h00, 8'h44, "top_layer"};
    vecs[10] = '{1'b1, 4'b0000, 1'b1, 1'b0, 8'h00, 8'h00, 8'hE3, "no_layer_bg"};
    vecs[11] = '{1'b1, 4'b0000, 1'b0, 1'b1, 8'h40, 8'h0F, 8'hE3, "restore_mask"};
    vecs[12] = '{1'b1, 4'b0001, 1'b1, 1'b1, 8'h40, 8'h00, 8'h11, "same_edge_write"};
    vecs[13] = '{1'b1, 4'b0001, 1'b1, 1'b0, 8'h00, 8'h00, 8'hE3, "after_same_edge"};
    vecs[14] = '{1'b1, 4'b0001, 1'b0, 1'b1, 8'h40, 8'h0F, 8'hE3, "restore_mask2"};
    vecs[15] = '{1'b1, 4'b0001, 1'b1, 1'b1, 8'h44, 8'h00, 8'h11, "ignored_port"};

    #1;
    checkValue("reset_rgb", {24'h0, rgb}, 32'h0);
    checkValue("reset_blink0", {31'h0, blink0}, 32'h0);
    checkValue("reset_blink1", {31'h0, blink1}, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i])
      applyStimulus(vecs[i].vo, vecs[i].lon, vecs[i].tick, vecs[i].wr,
                    vecs[i].port, vecs[i].data, vecs[i].exp_rgb, vecs[i].name);
    applyStimulus(1'b1, 4'b0001, 1'b1, 1'b0, 8'h00, 8'h00, 8'h11, "after_ignored_port");

    $display("[TB] blink on layer 0 from generator 0");
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1, 8'h41, 8'h01, last_exp, "write_blink_en");
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1, 8'h42, 8'h00, last_exp, "write_blink_sel0");
    for (int c = 0; c < 24; c++)
      applyStimulus(1'b1, 4'b0001, 1'b1, 1'b0, 8'h00, 8'h00, m_b0 ? 8'h11 : 8'hE3, "blink0_capture");
    measureHalf(1'b0, 4, "blink0_half_period");

    $display("[TB] blink on layer 0 from generator 1");
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1, 8'h42, 8'h01, last_exp, "write_blink_sel1");
    for (int c = 0; c < 36; c++)
      applyStimulus(1'b1, 4'b0001, 1'b1, 1'b0, 8'h00, 8'h00, m_b1 ? 8'h11 : 8'hE3, "blink1_capture");
    measureHalf(1'b1, 6, "blink1_half_period");

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 4'b0010, 1'b1, 1'b0, 8'h00, 8'h00, 8'h22, "pre_reset_rgb");
    applyStimulus(1'b1, 4'b0010, 1'b0, 1'b1, 8'h40, 8'h00, 8'h22, "pre_reset_mask0");
    applyStimulus(1'b1, 4'b0010, 1'b0, 1'b1, 8'h41, 8'h0F, 8'h22, "pre_reset_blink_en");
    for (int c = 0; c < 10 && m_b0 !== 1'b1; c++) holdStep();
    checkValue("pre_reset_blink0_high", {31'h0, blink0}, 32'h1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkValue("async_reset_rgb", {24'h0, rgb}, 32'h0);
    checkValue("async_reset_blink0", {31'h0, blink0}, 32'h0);
    checkValue("async_reset_blink1", {31'h0, blink1}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    last_exp = 8'h00;
    applyStimulus(1'b1, 4'b0001, 1'b1, 1'b1, 8'h44, 8'h00, 8'h11, "post_reset_mask_f");
    applyStimulus(1'b1, 4'b0001, 1'b1, 1'b0, 8'h00, 8'h00, 8'h11, "post_ignored_write");
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, "post_reset_bg");
    applyStimulus(1'b1, 4'b0100, 1'b1, 1'b0, 8'h00, 8'h00, 8'h33, "post_reset_layer2");

    if (sb.size() != 0) checkValue("scoreboard_leftover", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
